// File: rtl/bsg_cover_arbiter.sv
// Purpose: shares one downstream coverage channel among num_p collectors, one packet per grant, round-robin; also sequences a global drain.
// Latency: 1 cycle of arbitration in IDLE, then the granted collector's words pass combinationally while LOCKed.
// Backpressure: ready_i is steered only to the granted collector; others stall with ready_o=0 until their turn.
// Optional: define BSG_COVER_ARBITER_STATS_EN to add pkt_count_o / word_count_o statistics counters.
module bsg_cover_arbiter #(
    parameter int num_p   = 4,
    parameter int width_p = 32,
    localparam int lg_num_lp = (num_p > 1) ? $clog2(num_p) : 1
) (
    input  logic                       ds_clk_i,
    input  logic                       ds_reset_n_i,
    input  logic [num_p-1:0]           v_i,
    input  logic [num_p-1:0]           idx_v_i,
    input  logic [num_p*width_p-1:0]   data_i,
    input  logic [num_p-1:0]           gate_i,
    output logic [num_p-1:0]           ready_o,
    output logic [num_p-1:0]           drain_o,
    input  logic                       drain_req_i,
    output logic                       drain_busy_o,
    output logic                       drain_done_o,
    output logic                       v_o,
    output logic                       idx_v_o,
    output logic [lg_num_lp-1:0]       src_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i
`ifdef BSG_COVER_ARBITER_STATS_EN
    ,
    output logic [31:0]                pkt_count_o,
    output logic [31:0]                word_count_o
`endif
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e               state_r, state_n;
    logic [lg_num_lp-1:0] grant_r, grant_n;
    logic [lg_num_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic                 release_pkt;

    logic [num_p-1:0]     req;
    logic                 found;
    logic [lg_num_lp-1:0] pick;

    logic [width_p-1:0]   data_arr [num_p];
    logic                 lock;

    logic [num_p-1:0]     pending_r, seen_r;
    logic [num_p-1:0]     pending_nxt;
    logic                 busy_r, done_r;

    assign req  = v_i & idx_v_i;
    assign lock = (state_r == LOCK);

    // Split the flat data bus into one word per collector.
    always_comb begin
        for (int i = 0; i < num_p; i++) begin
            data_arr[i] = data_i[i*width_p +: width_p];
        end
    end

    // Rotating priority search: first header request at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = rr_ptr_r;
        for (int k = 0; k < num_p; k++) begin
            j = int'(rr_ptr_r) + k;
            if (j >= num_p) begin
                j = j - num_p;
            end
            if (!found && req[lg_num_lp'(j)]) begin
                found = 1'b1;
                pick  = lg_num_lp'(j);
            end
        end
    end

    // Arbiter next state: grant in IDLE, release when the owner is back in FILL with nothing valid.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        rr_ptr_n    = rr_ptr_r;
        release_pkt = 1'b0;
        case (state_r)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                if (!gate_i[grant_r] && !v_i[grant_r]) begin
                    state_n     = IDLE;
                    release_pkt = 1'b1;
                    rr_ptr_n    = (grant_r == lg_num_lp'(num_p - 1)) ? '0 : grant_r + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter registers.
    always_ff @(posedge ds_clk_i or negedge ds_reset_n_i) begin
        if (!ds_reset_n_i) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            rr_ptr_r <= rr_ptr_n;
        end
    end

    // Downstream mux: only the granted collector is visible, and only while LOCKed.
    always_comb begin
        v_o     = lock & v_i[grant_r];
        idx_v_o = lock & idx_v_i[grant_r];
        data_o  = lock ? data_arr[grant_r] : '0;
        ready_o = (lock && ready_i) ? (num_p'(1) << grant_r) : '0;
        src_o   = grant_r;
    end

    // A pending collector completes once it has been seen gated and its gate falls again.
    assign pending_nxt = pending_r & ~(seen_r & ~gate_i);

    // Drain sequencer: arm on request while idle, retire per collector, pulse done when all retire.
    always_ff @(posedge ds_clk_i or negedge ds_reset_n_i) begin
        if (!ds_reset_n_i) begin
            pending_r <= '0;
            seen_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (!busy_r) begin
            done_r <= 1'b0;
            if (drain_req_i) begin
                pending_r <= '1;
                seen_r    <= gate_i;
                busy_r    <= 1'b1;
            end
        end else begin
            pending_r <= pending_nxt;
            seen_r    <= seen_r | gate_i;
            if (pending_nxt == '0) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end
    end

    assign drain_o      = pending_r & ~seen_r;
    assign drain_busy_o = busy_r;
    assign drain_done_o = done_r;

`ifdef BSG_COVER_ARBITER_STATS_EN
    logic [31:0] pkt_count_r, word_count_r;

    // Packet and data-word statistics; both wrap naturally.
    always_ff @(posedge ds_clk_i or negedge ds_reset_n_i) begin
        if (!ds_reset_n_i) begin
            pkt_count_r  <= '0;
            word_count_r <= '0;
        end else begin
            if (release_pkt) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (v_o && ready_i && !idx_v_o) begin
                word_count_r <= word_count_r + 32'd1;
            end
        end
    end

    assign pkt_count_o  = pkt_count_r;
    assign word_count_o = word_count_r;
`endif

endmodule
